// File: rtl/rgb_layer_mux_pkg.sv
// Shared types and helpers for the RGB layer mux: pixel width, sync idle level, blink states.
// No logic, no latency.
package rgb_layer_mux_pkg;

  localparam int DEFAULT_COLOR_W = 4;
  localparam logic SYNC_IDLE = 1'b1;

  typedef enum logic {
    SHOW = 1'b0,
    HIDE = 1'b1
  } blink_state_e;

  function automatic int pw(input int color_w);
    return 3 * color_w;
  endfunction

  // Low bit of element idx in a packed bus of width-bit elements.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rgb_layer_mux_if.sv
// Pixel-stream bundle between a video timing/layer source and the layer mux.
// master drives pixel inputs and consumes RGB/syncs; slave is the mux.
interface rgb_layer_mux_if
  import rgb_layer_mux_pkg::*;
#(
  parameter int COLOR_W  = DEFAULT_COLOR_W,
  parameter int N_LAYERS = 3
);
  localparam int PW = pw(COLOR_W);

  logic                   pix_tick;
  logic                   frame_tick;
  logic                   video_on;
  logic                   hsync_in;
  logic                   vsync_in;
  logic [N_LAYERS*PW-1:0] layer_rgb;
  logic [N_LAYERS-1:0]    layer_on;
  logic [N_LAYERS-1:0]    layer_blink;
  logic [PW-1:0]          RGB;
  logic                   hsync_out;
  logic                   vsync_out;
  logic                   video_on_out;

  modport master (
    output pix_tick, frame_tick, video_on, hsync_in, vsync_in,
           layer_rgb, layer_on, layer_blink,
    input  RGB, hsync_out, vsync_out, video_on_out
  );

  modport slave (
    input  pix_tick, frame_tick, video_on, hsync_in, vsync_in,
           layer_rgb, layer_on, layer_blink,
    output RGB, hsync_out, vsync_out, video_on_out
  );

endinterface

// File: rtl/rgb_blink_ctr.sv
// Frame-based blink generator: blink_phase toggles every BLINK_DIV frame_ticks.
// Registered output, updates on the clk after frame_tick; no backpressure.
module rgb_blink_ctr
  import rgb_layer_mux_pkg::*;
#(
  parameter int BLINK_DIV = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  output logic blink_phase
);

  localparam logic [7:0] WRAP = 8'(BLINK_DIV - 1);

  logic [7:0]   cnt;
  blink_state_e state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      state       <= SHOW;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (cnt == WRAP) begin
        cnt <= '0;
        case (state)
          SHOW: begin
            state       <= HIDE;
            blink_phase <= 1'b1;
          end
          HIDE: begin
            state       <= SHOW;
            blink_phase <= 1'b0;
          end
          default: begin
            state       <= SHOW;
            blink_phase <= 1'b0;
          end
        endcase
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/rgb_layer_mux.sv
// Fixed-priority overlay mux (lowest visible layer wins) with blanking and blink.
// Latency 2 pix_tick-qualified cycles for RGB/syncs/video_on_out; outputs hold while pix_tick is low.
module rgb_layer_mux
  import rgb_layer_mux_pkg::*;
#(
  parameter int                       COLOR_W   = DEFAULT_COLOR_W,
  parameter int                       N_LAYERS  = 3,
  parameter int                       BLINK_DIV = 30,
  parameter logic [pw(COLOR_W)-1:0]   BG_RGB    = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  rgb_layer_mux_if.slave bus
);

  localparam int PW = pw(COLOR_W);

  logic                blink_phase;
  logic [N_LAYERS-1:0] visible;
  logic [PW-1:0]       sel_rgb;
  logic [PW-1:0]       s1_rgb;
  logic                s1_von;
  logic                s1_hs;
  logic                s1_vs;

  rgb_blink_ctr #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (bus.frame_tick),
    .blink_phase (blink_phase)
  );

  assign visible = bus.layer_on & ~(bus.layer_blink & {N_LAYERS{blink_phase}});

  // Walk from the highest index down so the lowest visible layer overwrites last.
  always_comb begin
    sel_rgb = BG_RGB;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (visible[i]) begin
        sel_rgb = bus.layer_rgb[slice_lo(i, PW) +: PW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rgb           <= '0;
      s1_von           <= 1'b0;
      s1_hs            <= SYNC_IDLE;
      s1_vs            <= SYNC_IDLE;
      bus.RGB          <= '0;
      bus.video_on_out <= 1'b0;
      bus.hsync_out    <= SYNC_IDLE;
      bus.vsync_out    <= SYNC_IDLE;
    end else if (bus.pix_tick) begin
      s1_rgb           <= sel_rgb;
      s1_von           <= bus.video_on;
      s1_hs            <= bus.hsync_in;
      s1_vs            <= bus.vsync_in;
      bus.RGB          <= s1_von ? s1_rgb : '0;
      bus.video_on_out <= s1_von;
      bus.hsync_out    <= s1_hs;
      bus.vsync_out    <= s1_vs;
    end
  end

endmodule

// File: tb/tb_rgb_layer_mux.sv
// Directed + random bench for rgb_layer_mux against a frame-count/queue reference model.
module tb_rgb_layer_mux;
  import rgb_layer_mux_pkg::*;

  localparam int          CW = 4;
  localparam int          NL = 3;
  localparam int          BD = 2;
  localparam int          PW = 12;
  localparam logic [11:0] BG = 12'h5A3;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        von;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rgb_layer_mux_if #(.COLOR_W(CW), .N_LAYERS(NL)) bus ();

  rgb_layer_mux #(
    .COLOR_W   (CW),
    .N_LAYERS  (NL),
    .BLINK_DIV (BD),
    .BG_RGB    (BG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  out_t pipe_q[$];
  out_t exp_o;
  int   frames;
  int   checks = 0;
  int   errors = 0;

  function automatic out_t idle_out();
    out_t o;
    o.rgb = 12'h000;
    o.hs  = 1'b1;
    o.vs  = 1'b1;
    o.von = 1'b0;
    return o;
  endfunction

  // Phase is derived from frames seen since reset; output is the pixel from one tick earlier.
  function automatic out_t model_pixel();
    out_t        o;
    logic [11:0] c;
    bit          hide;
    bit          found;
    hide  = ((frames / BD) % 2) == 1;
    c     = BG;
    found = 0;
    for (int i = 0; i < NL; i++) begin
      if (!found && bus.layer_on[i] && !(bus.layer_blink[i] && hide)) begin
        c     = bus.layer_rgb[i*PW +: PW];
        found = 1;
      end
    end
    o.rgb = bus.video_on ? c : 12'h000;
    o.hs  = bus.hsync_in;
    o.vs  = bus.vsync_in;
    o.von = bus.video_on;
    return o;
  endfunction

  function automatic bit model_hide();
    return ((frames / BD) % 2) == 1;
  endfunction

  task automatic reset_model();
    frames = 0;
    pipe_q = {};
    pipe_q.push_back(idle_out());
    exp_o = idle_out();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rgb"}, 32'(bus.RGB), 32'(exp_o.rgb));
    chk({tag, ".hs"}, 32'(bus.hsync_out), 32'(exp_o.hs));
    chk({tag, ".vs"}, 32'(bus.vsync_out), 32'(exp_o.vs));
    chk({tag, ".von"}, 32'(bus.video_on_out), 32'(exp_o.von));
  endtask

  task automatic set_pix(input logic von, input logic hs, input logic vs,
                         input logic [35:0] rgbs, input logic [2:0] on, input logic [2:0] blink);
    bus.video_on    = von;
    bus.hsync_in    = hs;
    bus.vsync_in    = vs;
    bus.layer_rgb   = rgbs;
    bus.layer_on    = on;
    bus.layer_blink = blink;
  endtask

  task automatic rand_pix();
    set_pix(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            36'({$urandom(), $urandom()}), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
  endtask

  // One clock: drive ticks, advance the model at the edge, compare at the falling edge.
  task automatic cyc(input logic pt, input logic ft, input string tag);
    out_t n;
    bus.pix_tick   = pt;
    bus.frame_tick = ft;
    @(posedge clk);
    if (rst_n) begin
      if (pt) begin
        n = model_pixel();
        pipe_q.push_back(n);
        exp_o = pipe_q.pop_front();
      end
      if (ft) frames++;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    reset_model();
    #1;
    check_outputs("reset_async");
    for (int k = 0; k < n; k++) begin
      rand_pix();
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "reset_hold");
    end
    rst_n = 1'b1;
  endtask

  int width;
  int first_low;
  int tick_n;
  logic [7:0]  blink_tbl;
  logic [11:0] blank_exp [3];
  logic        blank_von [3];
  logic        v;

  initial begin
    rst_n = 1'b0;
    bus.pix_tick   = 1'b0;
    bus.frame_tick = 1'b0;
    set_pix(1'b0, 1'b1, 1'b1, 36'h0, 3'b000, 3'b000);
    reset_model();
    @(negedge clk);

    // Reset with random inputs, then pix_tick every 4th clk.
    do_reset(6);
    set_pix(1'b1, 1'b1, 1'b1, {24'h0, 12'hABC}, 3'b001, 3'b000);
    tick_n = 0;
    for (int k = 0; k < 8; k++) begin
      cyc(1'(k % 4 == 3), 1'b0, "release");
      if (k % 4 == 3) begin
        tick_n++;
        if (tick_n == 1) chk("first_tick_rgb", 32'(bus.RGB), 32'h000);
        if (tick_n == 2) chk("first_valid_rgb", 32'(bus.RGB), 32'hABC);
      end
    end

    // Priority: layers 1 and 2 hit, layer 1 wins; then no hit shows background.
    set_pix(1'b1, 1'b1, 1'b1, {12'h00F, 12'h0F0, 12'hF00}, 3'b110, 3'b000);
    cyc(1'b1, 1'b0, "prio");
    cyc(1'b1, 1'b0, "prio");
    chk("prio_rgb", 32'(bus.RGB), 32'h0F0);
    set_pix(1'b1, 1'b1, 1'b1, {12'h00F, 12'h0F0, 12'hF00}, 3'b000, 3'b000);
    cyc(1'b1, 1'b0, "bg");
    cyc(1'b1, 1'b0, "bg");
    chk("bg_rgb", 32'(bus.RGB), 32'(BG));

    // Blanking overrides a hit layer.
    blank_exp[0] = 12'hFFF; blank_exp[1] = 12'h000; blank_exp[2] = 12'hFFF;
    blank_von[0] = 1'b1;    blank_von[1] = 1'b0;    blank_von[2] = 1'b1;
    set_pix(1'b1, 1'b1, 1'b1, {24'h0, 12'hFFF}, 3'b111, 3'b000);
    for (int k = 0; k < 4; k++) begin
      v = (k == 1) ? 1'b0 : 1'b1;
      set_pix(v, 1'b1, 1'b1, {24'h0, 12'hFFF}, 3'b001, 3'b000);
      cyc(1'b1, 1'b0, "blank");
      if (k >= 1) begin
        chk("blank_rgb", 32'(bus.RGB), 32'(blank_exp[k-1]));
        chk("blank_von", 32'(bus.video_on_out), 32'(blank_von[k-1]));
      end
    end

    // Blink with BLINK_DIV=2: layer 0 for two frames, layer 1 for two frames.
    @(negedge clk);
    do_reset(2);
    set_pix(1'b1, 1'b1, 1'b1, {12'h00F, 12'h0F0, 12'hF00}, 3'b011, 3'b001);
    blink_tbl = 8'b0110_0110;
    for (int f = 0; f < 8; f++) begin
      cyc(1'b0, 1'b1, "blink_frame");
      cyc(1'b1, 1'b0, "blink");
      cyc(1'b1, 1'b0, "blink");
      chk("blink_rgb", 32'(bus.RGB), blink_tbl[f] ? 32'h0F0 : 32'hF00);
    end

    // Sync alignment: 96-pixel hsync pulse with idle clocks between ticks.
    width     = 0;
    first_low = 0;
    for (int t = 1; t <= 106; t++) begin
      set_pix(1'b1, (t >= 5 && t <= 100) ? 1'b0 : 1'b1, 1'b1, {24'h0, 12'h321}, 3'b001, 3'b000);
      cyc(1'b0, 1'b0, "align_hold");
      cyc(1'b1, 1'b0, "align");
      if (bus.hsync_out == 1'b0) begin
        width++;
        if (first_low == 0) first_low = t;
      end
    end
    chk("hsync_width", 32'(width), 32'd96);
    chk("hsync_first_low_tick", 32'(first_low), 32'd6);

    // Random traffic, including frame_tick coincident with pix_tick.
    for (int k = 0; k < 300; k++) begin
      rand_pix();
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), "random");
    end

    // Mid-frame reset while hidden returns to SHOW with a cleared counter.
    set_pix(1'b1, 1'b1, 1'b1, {12'h00F, 12'h0F0, 12'hF00}, 3'b011, 3'b001);
    for (int k = 0; k < 8 && !model_hide(); k++) cyc(1'b0, 1'b1, "seek_hide");
    cyc(1'b1, 1'b0, "pre_reset");
    cyc(1'b1, 1'b0, "pre_reset");
    chk("hide_before_reset", 32'(bus.RGB), 32'h0F0);
    do_reset(3);
    set_pix(1'b1, 1'b1, 1'b1, {12'h00F, 12'h0F0, 12'hF00}, 3'b011, 3'b001);
    cyc(1'b1, 1'b0, "post_reset");
    cyc(1'b1, 1'b0, "post_reset");
    chk("show_after_reset", 32'(bus.RGB), 32'hF00);
    cyc(1'b0, 1'b1, "post_frame1");
    cyc(1'b1, 1'b0, "post_reset");
    cyc(1'b1, 1'b0, "post_reset");
    chk("cnt_cleared", 32'(bus.RGB), 32'hF00);
    cyc(1'b0, 1'b1, "post_frame2");
    cyc(1'b1, 1'b0, "post_reset");
    cyc(1'b1, 1'b0, "post_reset");
    chk("hide_after_div", 32'(bus.RGB), 32'h0F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
